aclk_controller: RTL and testbench
==================================

ACLK_CONTROLLER -- requirements
Module: aclk_controller

Interface
REQ-001 Parameter TIMEOUT_SECS, default 10, number of one_second pulses of inactivity that abandons key entry.
REQ-002 Parameter NOKEY, default 4'hA, key code meaning no key pressed.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 one_second  input  1  one-cycle pulse, once per second.
REQ-006 key  input  4  keypad code: 0-9 digit, NOKEY idle; 11-15 SHALL be treated as NOKEY.
REQ-007 alarm_button  input  1  level; high while the alarm button is held.
REQ-008 time_button  input  1  level; high while the time button is held.
REQ-009 show_new_time  output  1  display selects the key buffer.
REQ-010 show_a  output  1  display selects the alarm time.
REQ-011 shift  output  1  one-cycle pulse; key buffer shifts in key.
REQ-012 load_new_a  output  1  one-cycle pulse; alarm register loads the key buffer.
REQ-013 load_new_c  output  1  one-cycle pulse; current-time counter loads the key buffer.
REQ-014 reset_count  output  1  one-cycle pulse coincident with load_new_c; restarts the seconds prescaler.

Function
REQ-015 FSM states: SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM; all outputs registered (Moore, decoded into flops at the state-change edge).
REQ-016 SHOW_TIME: alarm_button -> SHOW_ALARM; else digit key -> KEY_STORED; else stay.
REQ-017 KEY_STORED: lasts exactly one cycle, shift=1 during it, unconditional -> KEY_WAITED.
REQ-018 KEY_WAITED: key==NOKEY -> KEY_ENTRY; timeout -> SHOW_TIME; else stay (held key SHALL NOT generate further shifts).
REQ-019 KEY_ENTRY: alarm_button -> SHOW_TIME with load_new_a pulse; else time_button -> SHOW_TIME with load_new_c and reset_count pulses; else digit key -> KEY_STORED; else timeout -> SHOW_TIME with no load; else stay.
REQ-020 SHOW_ALARM: show_a=1; alarm_button low -> SHOW_TIME.
REQ-021 show_new_time SHALL be 1 in KEY_STORED, KEY_WAITED, KEY_ENTRY and 0 elsewhere; show_a and show_new_time SHALL never be 1 together.
REQ-022 Priority in KEY_ENTRY: alarm_button > time_button > digit key > timeout.
REQ-023 Timeout counter (width ceil(log2(TIMEOUT_SECS+1))) increments on one_second only in KEY_WAITED or KEY_ENTRY; cleared in every other state.
REQ-024 Timeout asserts on the one_second pulse that would bring the count to TIMEOUT_SECS; counter SHALL never exceed TIMEOUT_SECS-1 and SHALL clear on exit.
REQ-025 load pulses SHALL be high exactly the one cycle after the deciding edge, simultaneous with show_new_time falling.
REQ-026 Buttons held across the return to SHOW_TIME: a still-high alarm_button in SHOW_TIME SHALL enter SHOW_ALARM next cycle (no edge detection).

Reset
REQ-027 reset SHALL force state SHOW_TIME, timeout counter 0, and all outputs 0 on the next rising edge, overriding any in-progress entry or pulse.
REQ-028 No load or shift pulse SHALL be emitted in the cycle following reset deassertion.

Structure
REQ-029 Shared package aclk_pkg SHALL hold the state enumeration, NOKEY default and digit-range constants for use by the keypad scanner and display blocks.
REQ-030 Timeout counter SHALL be a sub-module aclk_timeout_cnt (inputs clock, reset, enable, tick; output timeout).

Verification
REQ-031 Reset mid KEY_ENTRY with count 7 -> next cycle SHOW_TIME, all outputs 0, count 0.
REQ-032 Keys 1,2,3,4 each held 3 cycles separated by NOKEY, then time_button -> exactly 4 shift pulses, then load_new_c=1 and reset_count=1 for one cycle, show_new_time falls same cycle.
REQ-033 Key 5 then NOKEY, then 10 one_second pulses -> SHOW_TIME after 10th pulse, no load pulse; with 9 pulses stays KEY_ENTRY.
REQ-034 In KEY_ENTRY, alarm_button and time_button and key 7 asserted same cycle -> only load_new_a pulses, no shift.
REQ-035 In SHOW_TIME hold alarm_button 5 cycles -> show_a=1 for 5 cycles starting one cycle after press, show_new_time=0 throughout.
REQ-036 Key 8 held 20 cycles -> exactly one shift; key 12 in SHOW_TIME -> no transition.

Source files
------------

// File: rtl/aclk_pkg.sv
// aclk_pkg: shared alarm-clock types and keypad constants
package aclk_pkg;
   typedef enum logic [2:0] {SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY, SHOW_ALARM} state_t;
   localparam logic [3:0] NOKEY_DEF = 4'hA;
   localparam logic [3:0] DIGIT_MIN = 4'd0;
   localparam logic [3:0] DIGIT_MAX = 4'd9;
   function automatic logic is_digit(input logic [3:0] k);
      return k <= DIGIT_MAX;
   endfunction
endpackage

// File: rtl/aclk_timeout_cnt.sv
// aclk_timeout_cnt: counts one_second ticks while key entry is active
module aclk_timeout_cnt #(
   parameter int TIMEOUT_SECS = 10
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic tick,
   output logic timeout
);
   localparam int W = $clog2(TIMEOUT_SECS + 1);
   logic [W-1:0] count;
   assign timeout = enable && tick && (count == W'(TIMEOUT_SECS - 1));
   // count held at zero outside entry, wraps to zero on the abandoning tick
   always_ff @(posedge clock)
      if (reset || !enable) count <= '0;
      else if (tick) count <= timeout ? '0 : count + 1'b1;
endmodule

// File: rtl/aclk_controller.sv
// aclk_controller: alarm-clock keypad entry and display-select FSM
module aclk_controller
   import aclk_pkg::*;
#(
   parameter int         TIMEOUT_SECS = 10,
   parameter logic [3:0] NOKEY        = NOKEY_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic [3:0] key,
   input  logic       alarm_button,
   input  logic       time_button,
   output logic       show_new_time,
   output logic       show_a,
   output logic       shift,
   output logic       load_new_a,
   output logic       load_new_c,
   output logic       reset_count
);
   state_t state;
   logic   timeout;
   logic   digit;
   logic   entry;
   assign digit = is_digit(key) && key != NOKEY;
   assign entry = state == KEY_WAITED || state == KEY_ENTRY;
   aclk_timeout_cnt #(.TIMEOUT_SECS(TIMEOUT_SECS)) u_cnt (
      .clock(clock), .reset(reset), .enable(entry), .tick(one_second), .timeout(timeout)
   );
   // state and display selects follow the next state; pulses last one cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= SHOW_TIME;
         show_new_time <= 1'b0;
         show_a <= 1'b0;
         shift <= 1'b0;
         load_new_a <= 1'b0;
         load_new_c <= 1'b0;
         reset_count <= 1'b0;
      end else begin
         shift <= 1'b0;
         load_new_a <= 1'b0;
         load_new_c <= 1'b0;
         reset_count <= 1'b0;
         case (state)
            SHOW_TIME:
               if (alarm_button) begin
                  state <= SHOW_ALARM;
                  show_a <= 1'b1;
               end else if (digit) begin
                  state <= KEY_STORED;
                  show_new_time <= 1'b1;
                  shift <= 1'b1;
               end
            KEY_STORED: state <= KEY_WAITED;
            KEY_WAITED:
               if (!digit) state <= KEY_ENTRY;
               else if (timeout) begin
                  state <= SHOW_TIME;
                  show_new_time <= 1'b0;
               end
            KEY_ENTRY:
               if (alarm_button) begin
                  state <= SHOW_TIME;
                  show_new_time <= 1'b0;
                  load_new_a <= 1'b1;
               end else if (time_button) begin
                  state <= SHOW_TIME;
                  show_new_time <= 1'b0;
                  load_new_c <= 1'b1;
                  reset_count <= 1'b1;
               end else if (digit) begin
                  state <= KEY_STORED;
                  shift <= 1'b1;
               end else if (timeout) begin
                  state <= SHOW_TIME;
                  show_new_time <= 1'b0;
               end
            SHOW_ALARM:
               if (!alarm_button) begin
                  state <= SHOW_TIME;
                  show_a <= 1'b0;
               end
            default: begin
               state <= SHOW_TIME;
               show_new_time <= 1'b0;
               show_a <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_aclk_controller.sv
// tb_aclk_controller: scoreboard bench for the alarm-clock controller
module tb_aclk_controller;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       one_second = 1'b0;
   logic [3:0] key = 4'hA;
   logic       alarm_button = 1'b0;
   logic       time_button = 1'b0;
   logic       show_new_time, show_a, shift, load_new_a, load_new_c, reset_count;
   logic [5:0] outs;
   logic [5:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         shifts = 0;
   localparam logic [5:0] E_IDLE  = 6'b000000;
   localparam logic [5:0] E_SHIFT = 6'b101000;
   localparam logic [5:0] E_LA    = 6'b000100;
   localparam logic [5:0] E_LC    = 6'b000011;
   localparam logic [5:0] E_ENTRY = 6'b100000;
   localparam logic [5:0] E_ALARM = 6'b010000;
   localparam logic [3:0] NK      = 4'hA;
   assign outs = {show_new_time, show_a, shift, load_new_a, load_new_c, reset_count};
   aclk_controller dut (
      .clock(clock), .reset(reset), .one_second(one_second), .key(key),
      .alarm_button(alarm_button), .time_button(time_button),
      .show_new_time(show_new_time), .show_a(show_a), .shift(shift),
      .load_new_a(load_new_a), .load_new_c(load_new_c), .reset_count(reset_count)
   );
   always #5 clock = ~clock;
   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask
   task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask
   task automatic secs(input int n);
      repeat (n) begin
         one_second = 1'b1;
         cyc(1);
         one_second = 1'b0;
         cyc(1);
      end
   endtask
   task automatic enter(input logic [3:0] d);
      exp_q.push_back(E_SHIFT);
      key = d;
      cyc(1);
      key = NK;
      cyc(2);
   endtask
   initial begin
      fork
         forever begin
            @(negedge clock);
            if (shift) shifts++;
            if (!reset && (shift || load_new_a || load_new_c || reset_count)) begin
               if (exp_q.size() == 0) chk("unexpected_pulse", outs, E_IDLE);
               else chk("pulse", outs, exp_q.pop_front());
            end
         end
      join_none
      cyc(3);
      chk("reset_state", outs, E_IDLE);
      reset = 1'b0;
      cyc(1);
      chk("post_reset", outs, E_IDLE);
      key = 4'd12;
      cyc(3);
      chk("key12_idle", outs, E_IDLE);
      key = NK;
      for (int d = 1; d <= 4; d++) begin
         exp_q.push_back(E_SHIFT);
         key = 4'(d);
         cyc(3);
         key = NK;
         cyc(2);
         chk("entry_level", outs, E_ENTRY);
      end
      exp_q.push_back(E_LC);
      time_button = 1'b1;
      cyc(1);
      chk("load_c", outs, E_LC);
      time_button = 1'b0;
      cyc(1);
      chk("after_load_c", outs, E_IDLE);
      enter(4'd5);
      secs(9);
      chk("nine_secs", outs, E_ENTRY);
      one_second = 1'b1;
      cyc(1);
      chk("timeout", outs, E_IDLE);
      one_second = 1'b0;
      cyc(1);
      enter(4'd3);
      secs(7);
      checks++;
      if (dut.u_cnt.count !== 4'd7) begin
         errors++;
         $display("FAIL count7: got %0d expected 7", dut.u_cnt.count);
      end
      reset = 1'b1;
      cyc(1);
      chk("mid_reset", outs, E_IDLE);
      checks++;
      if (dut.u_cnt.count !== 4'd0) begin
         errors++;
         $display("FAIL count_cleared: got %0d expected 0", dut.u_cnt.count);
      end
      reset = 1'b0;
      cyc(1);
      chk("post_mid_reset", outs, E_IDLE);
      enter(4'd2);
      exp_q.push_back(E_LA);
      alarm_button = 1'b1;
      time_button = 1'b1;
      key = 4'd7;
      cyc(1);
      chk("load_a_priority", outs, E_LA);
      time_button = 1'b0;
      key = NK;
      cyc(1);
      chk("held_alarm", outs, E_ALARM);
      alarm_button = 1'b0;
      cyc(1);
      chk("alarm_release", outs, E_IDLE);
      alarm_button = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("show_alarm", outs, E_ALARM);
      end
      alarm_button = 1'b0;
      cyc(1);
      chk("show_alarm_end", outs, E_IDLE);
      exp_q.push_back(E_SHIFT);
      key = 4'd8;
      cyc(20);
      chk("held_key", outs, E_ENTRY);
      key = NK;
      cyc(1);
      exp_q.push_back(E_LA);
      alarm_button = 1'b1;
      cyc(1);
      alarm_button = 1'b0;
      cyc(3);
      chk("final_idle", outs, E_IDLE);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
      end
      checks++;
      if (shifts != 8) begin
         errors++;
         $display("FAIL shift_count: got %0d expected 8", shifts);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
